// File: rtl/operand_fetch_pkg.sv
// Shared constants and bypass source encoding for the operand fetch stage and
// the register file it reads.
package operand_fetch_pkg;

    localparam int unsigned DEF_ADDR  = 3;
    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoder-to-fetch and fetch-to-execute handshake bundle. The master side is
// the decoder/EX environment; the slave side is operand_fetch.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int unsigned ADDR  = DEF_ADDR,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [ADDR-1:0]  in_rs1;
    logic [ADDR-1:0]  in_rs2;
    logic             in_use1;
    logic             in_use2;
    logic [ADDR-1:0]  in_rd;
    logic             in_wr;
    logic             in_is_load;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_op1;
    logic [WIDTH-1:0] out_op2;
    logic [ADDR-1:0]  out_rd;
    logic             out_wr;
    logic             out_is_load;

    modport master (
        output in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wr, in_is_load,
        input  in_ready,
        input  out_valid, out_op1, out_op2, out_rd, out_wr, out_is_load,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wr, in_is_load,
        output in_ready,
        output out_valid, out_op1, out_op2, out_rd, out_wr, out_is_load,
        input  out_ready
    );

endinterface

// File: rtl/operand_fetch_fwd_sel.sv
// One operand's bypass resolution: EX > MEM > WB > register file, forced to
// zero when the operand is not read.
module operand_fetch_fwd_sel
    import operand_fetch_pkg::*;
#(
    parameter int unsigned ADDR  = DEF_ADDR,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             use_src,
    input  logic [ADDR-1:0]  rs,
    input  logic [WIDTH-1:0] rf_data,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic [ADDR-1:0]  ex_rd,
    input  logic [WIDTH-1:0] ex_data,
    input  logic             mem_wr,
    input  logic [ADDR-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_wr,
    input  logic [ADDR-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] opnd
);

    fwd_src_e src;

    // A load in EX has no data yet; the load-use stall covers that case.
    always_comb begin
        src = FWD_RF;
        if (ex_wr && !ex_is_load && (ex_rd == rs)) begin
            src = FWD_EX;
        end else if (mem_wr && (mem_rd == rs)) begin
            src = FWD_MEM;
        end else if (wb_wr && (wb_rd == rs)) begin
            src = FWD_WB;
        end
    end

    always_comb begin
        opnd = '0;
        if (use_src) begin
            unique case (src)
                FWD_EX:  opnd = ex_data;
                FWD_MEM: opnd = mem_data;
                FWD_WB:  opnd = wb_data;
                default: opnd = rf_data;
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read requests, bypassing, load-use stall,
// ID/EX pipeline register and a saturating stall-cycle counter.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned ADDR  = DEF_ADDR,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    operand_fetch_if.slave   bus,
    output logic             rf_r1_en,
    output logic             rf_r2_en,
    output logic [ADDR-1:0]  rf_r1_addr,
    output logic [ADDR-1:0]  rf_r2_addr,
    input  logic [WIDTH-1:0] rf_r1_data,
    input  logic [WIDTH-1:0] rf_r2_data,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic [ADDR-1:0]  ex_rd,
    input  logic [WIDTH-1:0] ex_data,
    input  logic             mem_wr,
    input  logic [ADDR-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wb_wr,
    input  logic [ADDR-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic [CNTW-1:0]  stall_cnt
);

    logic [WIDTH-1:0] op1_res, op2_res;
    logic             hz, accept;

    logic             valid_q;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [ADDR-1:0]  rd_q;
    logic             wr_q, ld_q;
    logic [CNTW-1:0]  stall_q;

    assign rf_r1_en   = bus.in_valid && bus.in_use1;
    assign rf_r2_en   = bus.in_valid && bus.in_use2;
    assign rf_r1_addr = bus.in_rs1;
    assign rf_r2_addr = bus.in_rs2;

    operand_fetch_fwd_sel #(.ADDR(ADDR), .WIDTH(WIDTH)) u_fwd1 (
        .use_src    (bus.in_use1),
        .rs         (bus.in_rs1),
        .rf_data    (rf_r1_data),
        .ex_wr      (ex_wr),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_wr      (wb_wr),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .opnd       (op1_res)
    );

    operand_fetch_fwd_sel #(.ADDR(ADDR), .WIDTH(WIDTH)) u_fwd2 (
        .use_src    (bus.in_use2),
        .rs         (bus.in_rs2),
        .rf_data    (rf_r2_data),
        .ex_wr      (ex_wr),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_wr      (wb_wr),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .opnd       (op2_res)
    );

    assign hz = bus.in_valid && ex_wr && ex_is_load &&
                ((bus.in_use1 && (ex_rd == bus.in_rs1)) ||
                 (bus.in_use2 && (ex_rd == bus.in_rs2)));

    assign bus.in_ready = !hz && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            op1_q   <= op1_res;
            op2_q   <= op2_res;
            rd_q    <= bus.in_rd;
            wr_q    <= bus.in_wr;
            ld_q    <= bus.in_is_load;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Counts every hazard cycle; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hz && (stall_q != {CNTW{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_op1     = op1_q;
    assign bus.out_op2     = op2_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_wr      = wr_q;
    assign bus.out_is_load = ld_q;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scoreboard bench for operand_fetch: bypass priority, load-use stall,
// backpressure, flush, asynchronous reset and stall counter saturation.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        rf_r1_en, rf_r2_en;
    logic [2:0]  rf_r1_addr, rf_r2_addr;
    logic [15:0] rf_r1_data, rf_r2_data;
    logic        ex_wr, ex_is_load;
    logic [2:0]  ex_rd;
    logic [15:0] ex_data;
    logic        mem_wr;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        wb_wr;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] stall_cnt;

    operand_fetch_if #(.ADDR(3), .WIDTH(16)) bus ();

    operand_fetch #(.ADDR(3), .WIDTH(16), .CNTW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .rf_r1_en   (rf_r1_en),
        .rf_r2_en   (rf_r2_en),
        .rf_r1_addr (rf_r1_addr),
        .rf_r2_addr (rf_r2_addr),
        .rf_r1_data (rf_r1_data),
        .rf_r2_data (rf_r2_data),
        .ex_wr      (ex_wr),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_wr      (wb_wr),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall_cnt  (stall_cnt)
    );

    typedef struct packed {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [2:0]  rd;
        logic        wr;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] op1, input logic [15:0] op2,
                        input logic [2:0] rd, input logic wr, input logic ld);
        exp_t e;
        e.op1 = op1;
        e.op2 = op2;
        e.rd  = rd;
        e.wr  = wr;
        e.ld  = ld;
        sb.push_back(e);
    endtask

    // Pops the expected entry for an output consumed at the coming edge.
    task automatic edge_step();
        exp_t e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL sb_empty observed=out_valid expected=no_output");
            end else begin
                e = sb.pop_front();
                chk("out_op1", {16'h0, bus.out_op1}, {16'h0, e.op1});
                chk("out_op2", {16'h0, bus.out_op2}, {16'h0, e.op2});
                chk("out_rd", {29'h0, bus.out_rd}, {29'h0, e.rd});
                chk("out_wr", {31'h0, bus.out_wr}, {31'h0, e.wr});
                chk("out_is_load", {31'h0, bus.out_is_load}, {31'h0, e.ld});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                             input logic u2, input logic [2:0] rd, input logic wr,
                             input logic ld);
        bus.in_valid   = 1'b1;
        bus.in_rs1     = rs1;
        bus.in_use1    = u1;
        bus.in_rs2     = rs2;
        bus.in_use2    = u2;
        bus.in_rd      = rd;
        bus.in_wr      = wr;
        bus.in_is_load = ld;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        bus.in_use1 = 1'b0;
        bus.in_use2 = 1'b0;
        bus.in_rd = '0;
        bus.in_wr = 1'b0;
        bus.in_is_load = 1'b0;
        bus.out_ready = 1'b1;
        rf_r1_data = '0;
        rf_r2_data = '0;
        ex_wr = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
        mem_wr = 1'b0; mem_rd = '0; mem_data = '0;
        wb_wr = 1'b0; wb_rd = '0; wb_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_op1", {16'h0, bus.out_op1}, 32'h0);
        chk("rst_out_op2", {16'h0, bus.out_op2}, 32'h0);
        chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        rst = 1'b0;

        // No hazard, first accept right after reset release
        set_instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
        rf_r1_data = 16'h1234;
        rf_r2_data = 16'h00FF;
        #1;
        chk("rf_r1_en", {31'h0, rf_r1_en}, 32'h1);
        chk("rf_r2_en", {31'h0, rf_r2_en}, 32'h1);
        chk("rf_r1_addr", {29'h0, rf_r1_addr}, 32'h1);
        chk("rf_r2_addr", {29'h0, rf_r2_addr}, 32'h2);
        chk("in_ready_idle", {31'h0, bus.in_ready}, 32'h1);
        push(16'h1234, 16'h00FF, 3'd4, 1'b1, 1'b0);
        edge_step();
        chk("latency_out_valid", {31'h0, bus.out_valid}, 32'h1);

        // Bypass priority EX > MEM > WB > RF, both operands
        set_instr(3'd3, 1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
        ex_wr = 1'b1; ex_rd = 3'd3; ex_data = 16'hAAAA;
        mem_wr = 1'b1; mem_rd = 3'd3; mem_data = 16'hBBBB;
        wb_wr = 1'b1; wb_rd = 3'd3; wb_data = 16'hCCCC;
        rf_r1_data = 16'h0303;
        rf_r2_data = 16'h0505;
        #1;
        push(16'hAAAA, 16'hAAAA, 3'd5, 1'b1, 1'b0);
        edge_step();
        bus.in_rs2 = 3'd5;
        ex_wr = 1'b0;
        #1;
        push(16'hBBBB, 16'h0505, 3'd5, 1'b1, 1'b0);
        edge_step();
        mem_wr = 1'b0;
        #1;
        push(16'hCCCC, 16'h0505, 3'd5, 1'b1, 1'b0);
        edge_step();
        bus.in_use1 = 1'b0;
        #1;
        chk("rf_r1_en_unused", {31'h0, rf_r1_en}, 32'h0);
        push(16'h0000, 16'h0505, 3'd5, 1'b1, 1'b0);
        edge_step();
        // Register 0 is bypassed like any other
        set_instr(3'd0, 1'b1, 3'd5, 1'b1, 3'd6, 1'b0, 1'b1);
        wb_rd = 3'd0; wb_data = 16'h0F0F;
        rf_r1_data = 16'h1111;
        #1;
        push(16'h0F0F, 16'h0505, 3'd6, 1'b0, 1'b1);
        edge_step();
        wb_wr = 1'b0;

        // Load-use stall, then MEM bypass once the load leaves EX
        set_instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0);
        ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd2; ex_data = 16'hDEAD;
        rf_r1_data = 16'h0101;
        rf_r2_data = 16'h2222;
        #1;
        chk("hz_in_ready", {31'h0, bus.in_ready}, 32'h0);
        edge_step();
        chk("hz_bubble", {31'h0, bus.out_valid}, 32'h0);
        chk("hz_stall_cnt", {16'h0, stall_cnt}, 32'h1);
        ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_wr = 1'b1; mem_rd = 3'd2; mem_data = 16'h5A5A;
        #1;
        chk("hz_clear_in_ready", {31'h0, bus.in_ready}, 32'h1);
        push(16'h0101, 16'h5A5A, 3'd7, 1'b1, 1'b0);
        edge_step();
        chk("hz_out_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("hz_stall_hold", {16'h0, stall_cnt}, 32'h1);

        // Backpressure: held operands stay stable while bypass data moves
        mem_wr = 1'b0;
        bus.out_ready = 1'b0;
        set_instr(3'd3, 1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b0);
        ex_wr = 1'b1; ex_rd = 3'd3;
        rf_r2_data = 16'h0606;
        for (int i = 0; i < 3; i++) begin
            ex_data = 16'h1000 + 16'(i);
            #1;
            chk("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
            chk("bp_op1", {16'h0, bus.out_op1}, 32'h0101);
            chk("bp_op2", {16'h0, bus.out_op2}, 32'h5A5A);
            edge_step();
        end
        bus.out_ready = 1'b1;
        ex_data = 16'h7777;
        #1;
        chk("bp_release_in_ready", {31'h0, bus.in_ready}, 32'h1);
        push(16'h7777, 16'h0606, 3'd1, 1'b1, 1'b0);
        edge_step();
        bus.in_valid = 1'b0;
        ex_wr = 1'b0;
        #1;
        edge_step();
        chk("bp_drained", {31'h0, bus.out_valid}, 32'h0);
        chk("bp_sb_empty", sb.size(), 32'h0);

        // Flush kills a held instruction, then drops one accepted with it
        bus.out_ready = 1'b0;
        set_instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        #1;
        push(16'h0101, 16'h0606, 3'd3, 1'b1, 1'b0);
        edge_step();
        chk("fl_held_valid", {31'h0, bus.out_valid}, 32'h1);
        flush = 1'b1;
        sb.delete();
        #1;
        edge_step();
        chk("fl_held_killed", {31'h0, bus.out_valid}, 32'h0);
        bus.out_ready = 1'b1;
        #1;
        chk("fl_accept_ready", {31'h0, bus.in_ready}, 32'h1);
        edge_step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_dropped", {31'h0, bus.out_valid}, 32'h0);
        chk("fl_stall_kept", {16'h0, stall_cnt}, 32'h1);

        // Build out_valid=1 with stall_cnt=5, then reset asynchronously
        bus.out_ready = 1'b0;
        set_instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b1);
        rf_r1_data = 16'h4321;
        #1;
        push(16'h4321, 16'h0606, 3'd6, 1'b1, 1'b1);
        edge_step();
        ex_wr = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            edge_step();
        end
        chk("pre_rst_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("pre_rst_stall", {16'h0, stall_cnt}, 32'h5);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("arst_op1", {16'h0, bus.out_op1}, 32'h0);
        chk("arst_op2", {16'h0, bus.out_op2}, 32'h0);
        chk("arst_rd", {29'h0, bus.out_rd}, 32'h0);
        chk("arst_wr", {31'h0, bus.out_wr}, 32'h0);
        chk("arst_is_load", {31'h0, bus.out_is_load}, 32'h0);
        chk("arst_stall", {16'h0, stall_cnt}, 32'h0);
        #1;
        rst = 1'b0;

        // Stall counter saturation under a persistent load-use hazard
        bus.out_ready = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("sat_stall", {16'h0, stall_cnt}, 32'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_stall_hold", {16'h0, stall_cnt}, 32'hFFFF);
        ex_wr = 1'b0; ex_is_load = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        edge_step();
        chk("sat_stall_final", {16'h0, stall_cnt}, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
